bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly downstream of the Fibonacci core in the Fibonacci v2 display path. It takes the core's binary result on a start/done handshake and produces packed BCD digits for the seven-segment multiplexer. The output register holds the last result, so the display stays stable while a new conversion runs.

## Interface
Parameters:
- BIN_W, default 20: width of the binary input. 20 bits covers Fibonacci results up to 1,048,575.
- DIGITS, default 7: number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W − 1; the implementation checks this at elaboration.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; sampled on the same edge as start.
- ready  output  1  high only in IDLE.
- done_tick  output  1  one-cycle pulse when the result is written to bcd.
- bcd  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]; holds its value between conversions.

## Operation
- States are IDLE, OP and DONE.
- IDLE:
  - ready = 1.
  - On start = 1: load bin into the shift register bin_r, clear the working BCD register bcd_w to 0, set bit counter n = BIN_W, go to OP.
  - start = 0: stay in IDLE.
- OP, every cycle:
  - For each digit of bcd_w, form adj_i = digit_i + 3 if digit_i ≥ 5, else digit_i. The adjustment is 4-bit and never overflows, because a digit is ≤ 9 before adjustment.
  - Next bcd_w = {adjusted digits shifted left 1, msb of bin_r}. Next bin_r = bin_r << 1. n decrements by 1.
  - When n = 1 on this edge (the last shift), copy the next bcd_w value into the bcd output register and go to DONE.
- DONE: done_tick = 1, ready = 0, go to IDLE unconditionally.
- start is ignored while in OP or DONE. The bin input is not re-sampled during a conversion.
- bcd changes only on the edge that enters DONE (and on reset). Every digit it presents is in the range 0–9.
- Reset (any state, including mid-conversion): state = IDLE, bin_r = 0, bcd_w = 0, n = 0, bcd = 0, ready = 1, done_tick = 0. A conversion cut off by reset produces no done_tick, and bcd stays 0.
- If start is held high continuously, a new conversion begins every BIN_W+2 cycles: it is re-sampled in the IDLE cycle that follows DONE.

## Timing
- ready and done_tick are decoded from the state register (Moore outputs), with no combinational path from any input.
- Let edge E be the edge that samples start = 1 in IDLE:
  - ready falls after E.
  - The shifts occur on edges E+1 through E+BIN_W.
  - bcd updates on edge E+BIN_W.
  - done_tick is high for exactly the cycle between edges E+BIN_W and E+BIN_W+1.
  - ready returns high after edge E+BIN_W+1.
- Latency from start to done_tick is BIN_W+1 cycles: 21 cycles at default parameters. Throughput is one conversion per BIN_W+2 cycles.
- The first cycle after rst is released is an IDLE cycle, and start is accepted in it.

## Test plan
- Reset, then start with bin = 0 → done_tick 21 cycles later; bcd = 0x0000000; ready high before and after.
- bin = 55 (fib(10)) → bcd = 0x0000055 exactly in the done_tick cycle; bcd stays 0x0000055 through a later 100-cycle idle period.
- Back-to-back conversions with bin = 6765, then 10946, then 1048575 (all-ones for 20 bits), start held high → done pulses 22 cycles apart. bcd reads 0x0006765, then 0x0010946, then 0x1048575. The previous value is held until each new done.
- Start bin = 6765; 5 cycles later, pulse start with bin = 99 → the second start is ignored; the result is 0x0006765 with a single done_tick.
- Start bin = 10946; assert rst in cycle 10 → the next cycle shows ready = 1 and bcd = 0, and no done_tick occurs. A new start with bin = 75025 then yields 0x0075025.
- Self-checking sweep of bin over 0–9999 plus 1000 random 20-bit values, compared against a reference decimal conversion → all match, and every digit ≤ 9.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Takes a binary value on a start/done handshake and presents packed BCD digits.
// The bcd output register holds the last result while a new conversion runs.
module bin2bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(BIN_W + 1);

  // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit digits_ok();
    longint unsigned p;
    longint unsigned max_bin;
    p = 64'd1;
    for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
    max_bin = (64'd1 << BIN_W) - 64'd1;
    return p > max_bin;
  endfunction

  if (!digits_ok()) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [BIN_W-1:0]      bin_r;
  logic [4*DIGITS-1:0]   bcd_w;
  logic [CW-1:0]         n;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   bcd_next;

  // Add-3 correction on every digit >= 5, then shift in the next binary msb.
  always_comb begin
    logic [3:0] dig;
    dig     = '0;
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bcd_w[4*i +: 4];
      bcd_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    bcd_next = {bcd_adj[4*DIGITS-2:0], bin_r[BIN_W-1]};
  end

  // Control FSM with datapath registers; ready and done_tick are registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_r     <= '0;
      bcd_w     <= '0;
      n         <= '0;
      bcd       <= '0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_r <= bin;
            bcd_w <= '0;
            n     <= CW'(BIN_W);
            ready <= 1'b0;
            state <= OP;
          end
        end
        OP: begin
          bcd_w <= bcd_next;
          bin_r <= bin_r << 1;
          n     <= n - CW'(1);
          if (n == CW'(1)) begin
            bcd       <= bcd_next;
            done_tick <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
